// File: rtl/sys_defs.sv
// sys_defs: shared bus/memory enums, default sizing and byte-enable helper.
package sys_defs;
  typedef enum logic [1:0] {BUS_NONE = 2'h0, BUS_LOAD = 2'h1, BUS_STORE = 2'h2} BUS_COMMAND;
  typedef enum logic [1:0] {BYTE = 2'h0, HALF = 2'h1, WORD = 2'h2, DOUBLE = 2'h3} MEM_SIZE;
  localparam int MEM_LATENCY = 4;
  localparam int NUM_MEM_TAGS = 15;
  localparam int MEM_DEPTH = 8192;
  function automatic logic [7:0] byte_en(MEM_SIZE size, logic [2:0] off);
    return (size == BYTE ? 8'h01 : size == HALF ? 8'h03 : size == WORD ? 8'h0f : 8'hff) << off;
  endfunction
endpackage

// File: rtl/mem_tag_pool.sv
// mem_tag_pool: free-tag tracking, per-tag latency countdown and data slots, completion register.
module mem_tag_pool #(
  parameter int NUM_TAGS = sys_defs::NUM_MEM_TAGS,
  parameter int LATENCY = sys_defs::MEM_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alloc,
  input  logic [63:0] alloc_data,
  output logic [3:0]  grant,
  output logic [3:0]  cpl_tag,
  output logic [63:0] cpl_data
);
  localparam int CW = $clog2(LATENCY + 1);
  logic [NUM_TAGS:1] busy;
  logic [CW-1:0] cnt [1:NUM_TAGS];
  logic [63:0] slot [1:NUM_TAGS];
  logic [3:0] nxt_tag;
  logic [63:0] nxt_data;
  always_comb begin
    grant = '0;
    for (int i = NUM_TAGS; i >= 1; i--) if (!busy[i]) grant = 4'(i);
  end
  // cnt reaches 1 the cycle before completion; latency 1 completes straight from the grant
  always_comb begin
    nxt_tag = '0;
    nxt_data = '0;
    for (int i = 1; i <= NUM_TAGS; i++)
      if (busy[i] && cnt[i] == CW'(1)) begin
        nxt_tag = 4'(i);
        nxt_data = slot[i];
      end
    if (LATENCY == 1 && alloc) begin
      nxt_tag = grant;
      nxt_data = alloc_data;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      busy <= '0;
      for (int i = 1; i <= NUM_TAGS; i++) cnt[i] <= '0;
      cpl_tag <= '0;
      cpl_data <= '0;
    end else begin
      cpl_tag <= nxt_tag;
      cpl_data <= nxt_data;
      for (int i = 1; i <= NUM_TAGS; i++)
        if (alloc && grant == 4'(i)) begin
          busy[i] <= 1'b1;
          cnt[i] <= CW'(LATENCY - 1);
        end else if (busy[i]) begin
          if (cnt[i] == '0) busy[i] <= 1'b0;
          else cnt[i] <= cnt[i] - 1'b1;
        end
    end
  always_ff @(posedge clock)
    if (alloc) slot[grant] <= alloc_data;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: tagged fixed-latency 64-bit memory on the unified bus.
// Define MEM_LFSR_STALL_EN to add pseudo-random request rejection from a 16-bit LFSR.
module mem_responder #(
  parameter int MEM_DEPTH = sys_defs::MEM_DEPTH,
  parameter int MEM_LATENCY = sys_defs::MEM_LATENCY,
  parameter int NUM_TAGS = sys_defs::NUM_MEM_TAGS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  input  logic [1:0]  proc2mem_size,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);
  import sys_defs::*;
  localparam int AW = $clog2(MEM_DEPTH);
  logic [63:0] mem [MEM_DEPTH];
  MEM_SIZE size;
  logic [AW-1:0] idx;
  logic [2:0] off;
  logic [7:0] be;
  logic [63:0] rd, wide, merged;
  logic aligned, ok, stall, accept, store;
  logic [3:0] grant;
  assign size = MEM_SIZE'(proc2mem_size);
  assign off = proc2mem_addr[2:0];
  assign idx = proc2mem_addr[AW+2:3];
  assign rd = mem[idx];
  assign wide = proc2mem_data << {off, 3'b000};
  assign be = byte_en(size, off);
  genvar b;
  for (b = 0; b < 8; b++) begin : g_byte
    assign merged[8*b+:8] = be[b] ? wide[8*b+:8] : rd[8*b+:8];
  end
  assign aligned = size == HALF ? !proc2mem_addr[0] :
                   size == WORD ? off[1:0] == 2'b00 :
                   size == DOUBLE ? off == 3'b000 : 1'b1;
  assign store = proc2mem_command == BUS_STORE;
  assign ok = proc2mem_command != BUS_NONE && proc2mem_addr[31:3] < 29'(MEM_DEPTH) && aligned;
`ifdef MEM_LFSR_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clock or negedge reset)
    if (!reset) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif
  // reset gates the grant so nothing is accepted while the pool is held clear
  assign accept = reset && ok && !stall && grant != 4'd0;
  assign mem2proc_response = accept ? grant : 4'd0;
  always_ff @(posedge clock)
    if (accept && store) mem[idx] <= merged;
  mem_tag_pool #(.NUM_TAGS(NUM_TAGS), .LATENCY(MEM_LATENCY)) u_pool (
    .clock(clock),
    .reset(reset),
    .alloc(accept),
    .alloc_data(store ? merged : rd),
    .grant(grant),
    .cpl_tag(mem2proc_tag),
    .cpl_data(mem2proc_data)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (latency 4 and 20) checked every cycle against a tag/memory model.
module tb_mem_responder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [1:0] cmd = '0, size = '0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [3:0] resp [2];
  logic [3:0] tag [2];
  logic [63:0] data [2];
  int checks = 0, errors = 0, cyc = 0;
  int lat [2] = '{4, 20};
  int busy_til [2][16];
  logic [3:0] et [2][int];
  logic [63:0] ed [2][int];
  logic [63:0] mm [2][8192];
  logic [15:0] lfsr = 16'hACE1;
  logic acc [2];

  always #5 clock = ~clock;

  mem_responder d0 (
    .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .proc2mem_size(size), .mem2proc_response(resp[0]),
    .mem2proc_data(data[0]), .mem2proc_tag(tag[0])
  );
  mem_responder #(.MEM_LATENCY(20)) d1 (
    .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .proc2mem_size(size), .mem2proc_response(resp[1]),
    .mem2proc_data(data[1]), .mem2proc_tag(tag[1])
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // one bus cycle: drive, compare against the model, then let the model absorb the grant
  task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                      input logic [1:0] s, input logic r);
    logic [3:0] er;
    logic [63:0] v;
    logic stall, ok;
    @(negedge clock);
    cmd = c; addr = a; wdata = d; size = s; reset = r;
    #1;
    if (!r) lfsr = 16'hACE1;
    stall = 1'b0;
`ifdef MEM_LFSR_STALL_EN
    stall = lfsr[0];
`endif
    ok = r && c != 2'd0 && (a >> 3) < 8192 && a % (1 << s) == 0 && !stall;
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        for (int t = 0; t < 16; t++) busy_til[k][t] = -1;
        et[k].delete();
        ed[k].delete();
      end
      er = '0;
      if (ok) for (int t = 15; t >= 1; t--) if (busy_til[k][t] < cyc) er = 4'(t);
      check($sformatf("resp%0d@%0d", k, cyc), 64'(resp[k]), 64'(er));
      check($sformatf("tag%0d@%0d", k, cyc), 64'(tag[k]), et[k].exists(cyc) ? 64'(et[k][cyc]) : 64'd0);
      check($sformatf("data%0d@%0d", k, cyc), data[k], ed[k].exists(cyc) ? ed[k][cyc] : 64'd0);
      acc[k] = er != 4'd0;
      if (er != 4'd0) begin
        v = mm[k][a[15:3]];
        if (c == 2'd2)
          for (int n = 0; n < 8; n++)
            if (n >= a[2:0] && n < a[2:0] + (1 << s)) v[8*n+:8] = d[8*(n-a[2:0])+:8];
        mm[k][a[15:3]] = v;
        busy_til[k][er] = cyc + lat[k];
        et[k][cyc+lat[k]] = er;
        ed[k][cyc+lat[k]] = v;
      end
    end
    if (r) lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'd0, 32'd0, 64'd0, 2'd0, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0] s;
    int n;
    for (int k = 0; k < 2; k++) for (int t = 0; t < 16; t++) busy_til[k][t] = -1;
    step(2'd1, 32'h100, 64'd0, 2'd3, 1'b0);
    step(2'd2, 32'h100, 64'h1, 2'd3, 1'b0);
    for (int w = 0; w < 64; w++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      n = 0;
      do begin
        step(2'd2, 32'(w * 8), d, 2'd3, 1'b1);
        n++;
      end while (!(acc[0] && acc[1]) && n < 200);
      check($sformatf("init_store_w%0d", w), 64'(n < 200), 64'd1);
    end
    idle(25);
    step(2'd1, 32'h100, 64'd0, 2'd3, 1'b1);
    idle(25);
    step(2'd2, 32'h104, 64'hDEADBEEF, 2'd2, 1'b1);
    step(2'd1, 32'h100, 64'd0, 2'd3, 1'b1);
    idle(25);
    for (int i = 0; i < 40; i++) step(2'd1, 32'(8 * (i % 64)), 64'd0, 2'd3, 1'b1);
    idle(25);
    step(2'd1, 32'h101, 64'd0, 2'd1, 1'b1);
    step(2'd1, 32'h10000, 64'd0, 2'd3, 1'b1);
    step(2'd2, 32'h102, 64'hFFFF_FFFF, 2'd2, 1'b1);
    step(2'd2, 32'h10000, 64'hFF, 2'd0, 1'b1);
    step(2'd1, 32'h100, 64'd0, 2'd3, 1'b1);
    idle(25);
    for (int i = 0; i < 3; i++) step(2'd1, 32'h100 + 32'(8 * i), 64'd0, 2'd3, 1'b1);
    idle(1);
    step(2'd0, 32'd0, 64'd0, 2'd0, 1'b0);
    step(2'd1, 32'h100, 64'd0, 2'd3, 1'b1);
    idle(25);
    for (int i = 0; i < 1500; i++) begin
      s = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 9) == 0) ? 32'h10000 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
      step(2'($urandom_range(0, 2)), a, {$urandom, $urandom}, s, $urandom_range(0, 299) != 0);
    end
    idle(25);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable, tagged, fixed-latency memory that answers the processor's unified memory bus: command/address/data/size in, response tag, data and completion tag out.
- Each request gets an accept tag in the same cycle, or 0 if rejected.
- Data for that tag comes back on a later cycle.
- Used as the memory endpoint in the top-level testbench and FPGA wrapper.

Parameters:
- MEM_DEPTH, 8192, number of 64-bit doublewords (64 KiB).
- MEM_LATENCY, 4, cycles from the accepting edge to the completion tag (must be ≥1).
- NUM_TAGS, 15, usable tags 1..NUM_TAGS. Tag 0 means "none". Must be ≤15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- proc2mem_command  in  2  BUS_COMMAND: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2.
- proc2mem_addr  in  32  byte address.
- proc2mem_data  in  64  store data, right-aligned to size.
- proc2mem_size  in  2  MEM_SIZE: BYTE=0, HALF=1, WORD=2, DOUBLE=3.
- mem2proc_response  out  4  accept tag (combinational); 0 means rejected or idle.
- mem2proc_data  out  64  completion data, valid when mem2proc_tag≠0.
- mem2proc_tag  out  4  completion tag (registered); 0 means no completion.

Behaviour:
- Reset (reset=0, async): clear all in-flight slots and free all tags. mem2proc_tag=0, mem2proc_data=0, mem2proc_response forced to 0. Memory array contents are preserved and not cleared.
- Acceptance (combinational, cycle c): the request is accepted iff all of the following hold:
  - command≠BUS_NONE;
  - addr[31:3] < MEM_DEPTH;
  - address is naturally aligned for its size (HALF: addr[0]=0; WORD: addr[1:0]=0; DOUBLE: addr[2:0]=0);
  - a free tag exists.
- On accept, mem2proc_response = lowest-numbered free tag. Otherwise mem2proc_response=0 and the request has no side effect; the requester retries.
- On the rising edge ending cycle c, an accepted request:
  - marks its tag busy and loads a countdown with MEM_LATENCY;
  - LOAD: snapshots doubleword mem[addr[31:3]] into the tag's data slot;
  - STORE: writes only the bytes selected by size and addr[2:0] (byte-enables), then snapshots the post-write doubleword into the slot.
- Completion: the registered output shows mem2proc_tag=T with mem2proc_data=slot[T] for exactly one cycle, cycle c+MEM_LATENCY. Loads always return the full doubleword; the requester extracts sub-words.
- One acceptance per cycle with fixed latency, so completions never collide. At most one tag completes per cycle.
- Tag reuse: T is released on the edge ending cycle c+MEM_LATENCY and may be granted again from cycle c+MEM_LATENCY+1. A completion and a new grant in the same cycle never share a tag.
- Ordering: same-address requests take effect in acceptance order. A LOAD accepted the cycle after a STORE to the same doubleword observes the stored bytes.
- Full: with NUM_TAGS busy, every request is rejected until a release.
- Mid-operation reset: all in-flight completions are dropped and never reported. Stores already committed remain in memory.
- Idle cycles: mem2proc_tag=0, mem2proc_data=0.

Optional Feature:
- MEM_LFSR_STALL_EN.
- Defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11; async reset value 16'hACE1) steps every cycle;
  - any otherwise-acceptable request is rejected (response 0) when lfsr[0]=1;
  - this exercises requester retry paths.
- Undefined: rejection only for the conditions listed above, and no LFSR is instantiated.

Decomposition:
- Shared package (sys_defs):
  - BUS_COMMAND enum and MEM_SIZE enum;
  - MEM_LATENCY, NUM_MEM_TAGS and MEM_DEPTH defaults;
  - a byte-enable helper function (size, offset → 8-bit mask).
- Sub-module mem_tag_pool holds the tag state: free bitmask, lowest-free priority encoder, per-tag countdowns and data slots, and the completion select.
- mem_responder keeps the array, decode and write logic.

Test Plan:
- Reset release, then LOAD addr 0x100 DOUBLE in cycle 0 → response=1 in cycle 0; tag=1 with mem[0x20] data in cycle 4; tag=0 in cycles 1–3 and 5.
- STORE addr 0x104 WORD data 0xDEADBEEF, then LOAD 0x100 DOUBLE next cycle → load completion upper word=0xDEADBEEF, lower word unchanged.
- 15 back-to-back LOADs with MEM_LATENCY=20 → responses 1..15; 16th request gets response 0; tag 1 is regranted in the cycle after its completion.
- Misaligned HALF at 0x101 and LOAD at addr 0x10000 (out of range) → response 0, no completion ever appears, memory unchanged.
- Reset pulsed low while tags 1–3 are in flight → no completion for 1–3 afterwards; the next LOAD is granted tag 1; stored data persists.
- MEM_LFSR_STALL_EN defined, LOAD retried every cycle → grant occurs only on cycles with lfsr[0]=0, and data is returned correctly.
